// File: rtl/data_mem_sized_pkg.sv
// ============================================================================
// Module      : data_mem_sized_pkg
// Description : Shared access-size encodings and FSM state type for the
//               sized data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_sized_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WORD_HI = 2'd1,
    RESP    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_bank16.sv
// ============================================================================
// Module      : dmem_bank16
// Description : Single-port 16-bit storage with two byte-lane write enables
//               and synchronous read (read returns pre-write contents).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bank16 #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we[0]) r_mem[addr][7:0]  <= wdata[7:0];
      if (we[1]) r_mem[addr][15:8] <= wdata[15:8];
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/data_mem_sized.sv
// ============================================================================
// Module      : data_mem_sized
// Description : Byte/halfword/word data memory over a 16-bit single-port bank.
//               Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_sized
  import data_mem_sized_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t               r_state;
  logic                 r_we;
  logic                 r_uns;
  logic                 r_lane;
  logic                 r_err_cur;
  logic [1:0]           r_size;
  logic [c_idx_w-1:0]   r_idx;
  logic [15:0]          r_wdata_hi;
  logic [15:0]          r_lo;
  logic [31:0]          r_rdata_hold;
  logic                 r_err_hold;

  logic                 w_accept;
  logic                 w_reject;
  logic                 w_lane;
  logic [c_idx_w-1:0]   w_idx;
  logic                 w_bank_en;
  logic [1:0]           w_bank_we;
  logic [c_idx_w-1:0]   w_bank_addr;
  logic [15:0]          w_bank_wdata;
  logic [15:0]          w_bank_rdata;
  logic [7:0]           w_byte;
  logic [31:0]          w_resp;

  assign ready    = (r_state != WORD_HI);
  assign w_accept = req & ready;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_reject = (size == SZ_RSVD) | ((size != SZ_BYTE) & addr[0]);
`else
  assign w_reject = (size == SZ_RSVD);
`endif

  // Half/word accesses always start on lane 0, which drops addr[0].
  assign w_lane = (size == SZ_BYTE) & addr[0];
  assign w_idx  = addr[c_idx_w:1];

  always_comb begin
    w_bank_en    = 1'b0;
    w_bank_we    = 2'b00;
    w_bank_addr  = w_idx;
    w_bank_wdata = wdata[15:0];
    if (r_state == WORD_HI) begin
      // Gated by rst_n so an aborted word store leaves the high entry intact.
      w_bank_en    = rst_n;
      w_bank_addr  = r_idx + c_idx_w'(1);
      w_bank_we    = {2{r_we & rst_n}};
      w_bank_wdata = r_wdata_hi;
    end else if (w_accept && !w_reject && rst_n) begin
      w_bank_en = 1'b1;
      if (we) begin
        if (size == SZ_BYTE) begin
          w_bank_we    = w_lane ? 2'b10 : 2'b01;
          w_bank_wdata = {2{wdata[7:0]}};
        end else begin
          w_bank_we = 2'b11;
        end
      end
    end
  end

  dmem_bank16 #(
    .DEPTH  (DEPTH),
    .ADDR_W (c_idx_w)
  ) u_bank (
    .clk   (clk),
    .en    (w_bank_en),
    .we    (w_bank_we),
    .addr  (w_bank_addr),
    .wdata (w_bank_wdata),
    .rdata (w_bank_rdata)
  );

  always_comb begin
    w_byte = r_lane ? w_bank_rdata[15:8] : w_bank_rdata[7:0];
    case (r_size)
      SZ_BYTE: w_resp = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_resp = r_uns ? {16'd0, w_bank_rdata}
                              : {{16{w_bank_rdata[15]}}, w_bank_rdata};
      default: w_resp = {w_bank_rdata, r_lo};
    endcase
    if (r_we || r_err_cur) w_resp = 32'd0;
  end

  assign rvalid = (r_state == RESP);
  assign rdata  = rvalid ? w_resp    : r_rdata_hold;
  assign err    = rvalid ? r_err_cur : r_err_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_err_cur    <= 1'b0;
      r_rdata_hold <= 32'd0;
      r_err_hold   <= 1'b0;
    end else begin
      if (r_state == RESP) begin
        r_rdata_hold <= w_resp;
        r_err_hold   <= r_err_cur;
      end
      if (r_state == WORD_HI) begin
        r_lo    <= w_bank_rdata;
        r_state <= RESP;
      end else if (w_accept) begin
        r_we       <= we;
        r_uns      <= uns;
        r_size     <= size;
        r_lane     <= w_lane;
        r_idx      <= w_idx;
        r_wdata_hi <= wdata[31:16];
        r_err_cur  <= w_reject;
        r_state    <= (size == SZ_WORD && !w_reject) ? WORD_HI : RESP;
      end else begin
        r_state <= IDLE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_sized.sv
// ============================================================================
// Module      : tb_data_mem_sized
// Description : Directed self-checking bench for data_mem_sized (DEPTH=256).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_sized;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  data_mem_sized #(
    .DEPTH  (256),
    .ADDR_W (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .we     (we),
    .size   (size),
    .uns    (uns),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .rvalid (rvalid),
    .rdata  (rdata),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request, returns the response and accept-to-rvalid latency.
  // Inputs are scrambled right after accept to show they are not re-sampled.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; size = 2'b01; uns = ~u; addr = 32'hFFFF_FFFF; wdata = 32'hDEAD_BEEF;
    lat = 1;
    while (!rvalid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = rdata;
    e  = err;
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then load
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_7FFE, rd, e, lat);
    chk("wst_lat", 32'(lat), 32'd2);
    chk("wst_rdata", rd, 32'd0);
    chk("wst_err", 32'(e), 32'd0);
    issue(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, rd, e, lat);
    chk("wld_lat", 32'(lat), 32'd2);
    chk("wld_rdata", rd, 32'h8001_7FFE);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, e, lat);
    chk("entry8", rd, 32'h0000_7FFE);
    chk("hld_lat", 32'(lat), 32'd1);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, e, lat);
    chk("entry9", rd, 32'h0000_8001);

    // Byte lanes and extension
    issue(1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFF_1111, rd, e, lat);
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_56A5, rd, e, lat);
    chk("bst_lat", 32'(lat), 32'd1);
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, e, lat);
    chk("byte_sext", rd, 32'hFFFF_FFA5);
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, e, lat);
    chk("byte_zext", rd, 32'h0000_00A5);
    issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rd, e, lat);
    chk("byte_lo_kept", rd, 32'h0000_0011);

    // Wrap from entry 255 to entry 0
    issue(1'b1, 2'b10, 1'b0, 32'h1FE, 32'h1234_5678, rd, e, lat);
    issue(1'b0, 2'b01, 1'b1, 32'h1FE, 32'h0, rd, e, lat);
    chk("entry255", rd, 32'h0000_5678);
    issue(1'b0, 2'b01, 1'b1, 32'h0, 32'h0, rd, e, lat);
    chk("entry0", rd, 32'h0000_1234);
    issue(1'b0, 2'b10, 1'b0, 32'h1FE, 32'h0, rd, e, lat);
    chk("wrap_word", rd, 32'h1234_5678);

    // Alignment handling on entry 1
    issue(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_BEEF, rd, e, lat);
    issue(1'b0, 2'b01, 1'b1, 32'h3, 32'h0, rd, e, lat);
    chk("mis_lat", 32'(lat), 32'd1);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_rdata", rd, 32'd0);
`else
    chk("mis_err", 32'(e), 32'd0);
    chk("mis_rdata", rd, 32'h0000_BEEF);
`endif

    // Reserved size: rejected, no write, response held afterwards
    issue(1'b1, 2'b11, 1'b0, 32'h2, 32'h0000_0000, rd, e, lat);
    chk("rsv_lat", 32'(lat), 32'd1);
    chk("rsv_err", 32'(e), 32'd1);
    chk("rsv_rdata", rd, 32'd0);
    @(posedge clk);
    #1;
    chk("rsv_rvalid_drop", 32'(rvalid), 32'd0);
    chk("rsv_err_held", 32'(err), 32'd1);
    issue(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, rd, e, lat);
    chk("rsv_nowrite", rd, 32'hFFFF_BEEF);
    chk("err_cleared", 32'(e), 32'd0);
    @(posedge clk);
    #1;
    chk("rdata_held", rdata, 32'hFFFF_BEEF);

    // Back-to-back byte loads
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b00; uns = 1'b1; addr = 32'h21;
    @(posedge clk);
    #1;
    chk("b2b_rv1", 32'(rvalid), 32'd1);
    chk("b2b_rd1", rdata, 32'h0000_00A5);
    @(negedge clk);
    chk("b2b_ready", 32'(ready), 32'd1);
    addr = 32'h20;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("b2b_rv2", 32'(rvalid), 32'd1);
    chk("b2b_rd2", rdata, 32'h0000_0011);
    @(posedge clk);
    #1;
    chk("b2b_rv_end", 32'(rvalid), 32'd0);

    // Word load stalls ready for exactly one cycle
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("wld_ready_lo", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk("wld_ready_hi", 32'(ready), 32'd1);
    chk("wld_rvalid", 32'(rvalid), 32'd1);

    // Reset during WORD_HI of a word store
    issue(1'b1, 2'b01, 1'b0, 32'h40, 32'h0000_AAAA, rd, e, lat);
    issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_BBBB, rd, e, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h1122_3344;
    @(posedge clk);
    #1;
    req = 1'b0;
    rst_n = 1'b0;
    chk("rst_wordhi_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_no_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_after_ready", 32'(ready), 32'd1);
    chk("rst_after_rvalid", 32'(rvalid), 32'd0);
    issue(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, rd, e, lat);
    chk("rst_lo_written", rd, 32'h0000_3344);
    issue(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, rd, e, lat);
    chk("rst_hi_kept", rd, 32'h0000_BBBB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
